// File: rtl/bus_arbiter_if.sv
// Fetch port, data port and memory port of the core bus arbiter.
// The slave modport is the arbiter's view; master is the cache/memory side.
interface bus_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_lock;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_error;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_lock;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_error;

    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_ack;
    logic [31:0] m_rdata;
    logic        m_error;

    modport slave (
        input  i_req, i_addr, i_lock,
        output i_ack, i_rdata, i_error,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb, d_lock,
        output d_ack, d_rdata, d_error,
        output m_req, m_we, m_addr, m_wdata, m_wstrb,
        input  m_ack, m_rdata, m_error
    );

    modport master (
        output i_req, i_addr, i_lock,
        input  i_ack, i_rdata, i_error,
        output d_req, d_we, d_addr, d_wdata, d_wstrb, d_lock,
        input  d_ack, d_rdata, d_error,
        input  m_req, m_we, m_addr, m_wdata, m_wstrb,
        output m_ack, m_rdata, m_error
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-requester memory bus arbiter: data-side priority, lockable ownership,
// and a streak counter that forces a fetch grant after MAX_D_STREAK data grants.
module bus_arbiter #(
    parameter int MAX_D_STREAK = 4,
    parameter int CNT_W        = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    bus_arbiter_if.slave     bus,
    output logic [1:0]       owner
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_I = 2'b01,
        OWN_D = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_D_STREAK);

    state_t           state, state_nx;
    logic [CNT_W-1:0] streak, streak_nx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            streak <= '0;
        end else begin
            state  <= state_nx;
            streak <= streak_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        streak_nx   = streak;
        bus.m_req   = 1'b0;
        bus.m_we    = 1'b0;
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        bus.m_wstrb = '0;
        bus.i_ack   = 1'b0;
        bus.i_error = 1'b0;
        bus.d_ack   = 1'b0;
        bus.d_error = 1'b0;

        case (state)
            IDLE: begin
                // m_ack seen here belongs to nobody and is dropped
                if (!bus.i_req)
                    streak_nx = '0;
                if (bus.i_req && (!bus.d_req || streak == STREAK_MAX)) begin
                    state_nx  = OWN_I;
                    streak_nx = '0;
                end else if (bus.d_req) begin
                    state_nx = OWN_D;
                    // reaching here with i_req set implies streak < STREAK_MAX
                    if (bus.i_req)
                        streak_nx = streak + CNT_W'(1);
                end
            end

            OWN_I: begin
                bus.m_req   = bus.i_req;
                bus.m_addr  = bus.i_addr;
                bus.i_ack   = bus.m_ack;
                bus.i_error = bus.m_ack & bus.m_error;
                if (bus.m_ack)
                    state_nx = bus.i_lock ? OWN_I : IDLE;
                else if (!bus.i_req && !bus.i_lock)
                    state_nx = IDLE;
            end

            OWN_D: begin
                bus.m_req   = bus.d_req;
                bus.m_we    = bus.d_we;
                bus.m_addr  = bus.d_addr;
                bus.m_wdata = bus.d_wdata;
                bus.m_wstrb = bus.d_wstrb;
                bus.d_ack   = bus.m_ack;
                bus.d_error = bus.m_ack & bus.m_error;
                if (bus.m_ack)
                    state_nx = bus.d_lock ? OWN_D : IDLE;
                else if (!bus.d_req && !bus.d_lock)
                    state_nx = IDLE;
            end

            default: state_nx = IDLE;
        endcase
    end

    assign bus.i_rdata = bus.m_rdata;
    assign bus.d_rdata = bus.m_rdata;
    assign owner       = state;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: cycle-by-cycle vector table plus
// hand-written starvation and reset-mid-transfer sequences.
module tb_bus_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] owner;

    bus_arbiter_if bus();

    bus_arbiter #(.MAX_D_STREAK(4), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .owner (owner)
    );

    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    localparam logic [31:0] IA0 = 32'h8000_0000, IA1 = 32'h8000_0004;
    localparam logic [31:0] IA2 = 32'h8000_0008, IA3 = 32'h8000_000C;
    localparam logic [31:0] IA4 = 32'h8000_0010;
    localparam logic [31:0] DA1 = 32'h8000_1000, DA2 = 32'h8000_2000;
    localparam logic [31:0] DA3 = 32'h8000_3000, DB  = 32'hDEAD_BEEF;

    // One row = inputs for a cycle and the outputs expected in that same cycle.
    typedef struct packed {
        logic [1:0]  ictl;   // {i_req, i_lock}
        logic [31:0] ia;
        logic [2:0]  dctl;   // {d_req, d_we, d_lock}
        logic [31:0] da;
        logic [31:0] dd;
        logic [3:0]  ds;
        logic [1:0]  mctl;   // {m_ack, m_error}
        logic [31:0] mr;
        logic [75:0] exp;    // {owner, m_req, m_we, m_addr, m_wdata, m_wstrb, i_ack, d_ack, i_error, d_error}
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic [1:0] ictl, input logic [31:0] ia,
        input logic [2:0] dctl, input logic [31:0] da, input logic [31:0] dd, input logic [3:0] ds,
        input logic [1:0] mctl, input logic [31:0] mr,
        input logic [1:0] own, input logic [1:0] mrw, input logic [31:0] maddr,
        input logic [31:0] mwd, input logic [3:0] mws, input logic [3:0] acks);
        vec_t v;
        v.ictl = ictl; v.ia = ia; v.dctl = dctl; v.da = da; v.dd = dd; v.ds = ds;
        v.mctl = mctl; v.mr = mr;
        v.exp  = {own, mrw, maddr, mwd, mws, acks};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [75:0] act, input logic [75:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [75:0] outs();
        return {owner, bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata, bus.m_wstrb,
                bus.i_ack, bus.d_ack, bus.i_error, bus.d_error};
    endfunction

    task automatic drive(input vec_t v);
        {bus.i_req, bus.i_lock} = v.ictl;
        bus.i_addr = v.ia;
        {bus.d_req, bus.d_we, bus.d_lock} = v.dctl;
        bus.d_addr = v.da; bus.d_wdata = v.dd; bus.d_wstrb = v.ds;
        {bus.m_ack, bus.m_error} = v.mctl;
        bus.m_rdata = v.mr;
    endtask

    initial begin
        int         dgr;
        bit         got_i;
        bit         overlap;
        logic [1:0] prev;
        logic [1:0] next_grant;

        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // fetch alone: bubble, two wait cycles, ack, back to idle
        vecs.push_back(mk(2'b00, 0,   3'b000, 0, 0, 0, 2'b00, 0,      2'b00, 2'b00, 0,   0, 0, 4'b0000));
        vecs.push_back(mk(2'b10, IA0, 3'b000, 0, 0, 0, 2'b00, 0,      2'b00, 2'b00, 0,   0, 0, 4'b0000));
        vecs.push_back(mk(2'b10, IA0, 3'b000, 0, 0, 0, 2'b00, 0,      2'b01, 2'b10, IA0, 0, 0, 4'b0000));
        vecs.push_back(mk(2'b10, IA0, 3'b000, 0, 0, 0, 2'b00, 0,      2'b01, 2'b10, IA0, 0, 0, 4'b0000));
        vecs.push_back(mk(2'b10, IA0, 3'b000, 0, 0, 0, 2'b10, 32'h13, 2'b01, 2'b10, IA0, 0, 0, 4'b1000));
        vecs.push_back(mk(2'b00, 0,   3'b000, 0, 0, 0, 2'b00, 0,      2'b00, 2'b00, 0,   0, 0, 4'b0000));
        // simultaneous requests: data write first, then fetch
        vecs.push_back(mk(2'b10, IA1, 3'b110, DA1, DB, 4'hF, 2'b00, 0,        2'b00, 2'b00, 0,   0,  0,    4'b0000));
        vecs.push_back(mk(2'b10, IA1, 3'b110, DA1, DB, 4'hF, 2'b00, 0,        2'b10, 2'b11, DA1, DB, 4'hF, 4'b0000));
        vecs.push_back(mk(2'b10, IA1, 3'b110, DA1, DB, 4'hF, 2'b10, 32'h5555, 2'b10, 2'b11, DA1, DB, 4'hF, 4'b0100));
        vecs.push_back(mk(2'b10, IA1, 3'b000, 0,   0,  0,    2'b00, 0,        2'b00, 2'b00, 0,   0,  0,    4'b0000));
        vecs.push_back(mk(2'b10, IA1, 3'b000, 0,   0,  0,    2'b00, 0,        2'b01, 2'b10, IA1, 0,  0,    4'b0000));
        vecs.push_back(mk(2'b10, IA1, 3'b000, 0,   0,  0,    2'b10, 32'h93,   2'b01, 2'b10, IA1, 0,  0,    4'b1000));
        vecs.push_back(mk(2'b00, 0,   3'b000, 0,   0,  0,    2'b00, 0,        2'b00, 2'b00, 0,   0,  0,    4'b0000));
        // locked 4-word refill with data waiting throughout
        vecs.push_back(mk(2'b11, IA0, 3'b000, 0,   0, 0, 2'b00, 0,     2'b00, 2'b00, 0,   0, 0, 4'b0000));
        vecs.push_back(mk(2'b11, IA0, 3'b100, DA2, 0, 0, 2'b00, 0,     2'b01, 2'b10, IA0, 0, 0, 4'b0000));
        vecs.push_back(mk(2'b11, IA0, 3'b100, DA2, 0, 0, 2'b10, 'hA0,  2'b01, 2'b10, IA0, 0, 0, 4'b1000));
        vecs.push_back(mk(2'b11, IA1, 3'b100, DA2, 0, 0, 2'b10, 'hA1,  2'b01, 2'b10, IA1, 0, 0, 4'b1000));
        vecs.push_back(mk(2'b11, IA2, 3'b100, DA2, 0, 0, 2'b10, 'hA2,  2'b01, 2'b10, IA2, 0, 0, 4'b1000));
        vecs.push_back(mk(2'b10, IA3, 3'b100, DA2, 0, 0, 2'b10, 'hA3,  2'b01, 2'b10, IA3, 0, 0, 4'b1000));
        vecs.push_back(mk(2'b00, 0,   3'b100, DA2, 0, 0, 2'b00, 0,     2'b00, 2'b00, 0,   0, 0, 4'b0000));
        vecs.push_back(mk(2'b00, 0,   3'b100, DA2, 0, 0, 2'b00, 0,     2'b10, 2'b10, DA2, 0, 0, 4'b0000));
        // data read with bus error, then a stray ack in idle
        vecs.push_back(mk(2'b00, 0,   3'b100, DA2, 0, 0, 2'b11, 'hBAD, 2'b10, 2'b10, DA2, 0, 0, 4'b0101));
        vecs.push_back(mk(2'b00, 0,   3'b000, 0,   0, 0, 2'b11, 'hBAD, 2'b00, 2'b00, 0,   0, 0, 4'b0000));
        // data lock held past ack, released without a transfer; fetch waits
        vecs.push_back(mk(2'b00, 0,   3'b101, DA3, 0, 0, 2'b00, 0,     2'b00, 2'b00, 0,   0, 0, 4'b0000));
        vecs.push_back(mk(2'b00, 0,   3'b101, DA3, 0, 0, 2'b10, 'hC0,  2'b10, 2'b10, DA3, 0, 0, 4'b0100));
        vecs.push_back(mk(2'b10, IA4, 3'b001, DA3, 0, 0, 2'b00, 0,     2'b10, 2'b00, DA3, 0, 0, 4'b0000));
        vecs.push_back(mk(2'b10, IA4, 3'b000, DA3, 0, 0, 2'b00, 0,     2'b10, 2'b00, DA3, 0, 0, 4'b0000));
        vecs.push_back(mk(2'b10, IA4, 3'b000, DA3, 0, 0, 2'b00, 0,     2'b00, 2'b00, 0,   0, 0, 4'b0000));
        vecs.push_back(mk(2'b10, IA4, 3'b000, DA3, 0, 0, 2'b10, 'hC1,  2'b01, 2'b10, IA4, 0, 0, 4'b1000));
        vecs.push_back(mk(2'b00, 0,   3'b000, 0,   0, 0, 2'b00, 0,     2'b00, 2'b00, 0,   0, 0, 4'b0000));

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (vecs[k]) begin
            drive(vecs[k]);
            @(negedge clk);
            chk($sformatf("vec%0d", k), outs(), vecs[k].exp);
            if (vecs[k].exp[3]) chk($sformatf("vec%0d_i_rdata", k), 76'(bus.i_rdata), 76'(vecs[k].mr));
            if (vecs[k].exp[2]) chk($sformatf("vec%0d_d_rdata", k), 76'(bus.d_rdata), 76'(vecs[k].mr));
            @(posedge clk);
            #1;
        end

        // starvation: zero-wait memory, both sides requesting continuously
        bus.i_req = 1'b1; bus.i_addr = IA0; bus.i_lock = 1'b0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = DA2; bus.d_lock = 1'b0;
        bus.d_wdata = '0; bus.d_wstrb = '0; bus.m_error = 1'b0; bus.m_rdata = 32'h1;
        dgr = 0; got_i = 1'b0; overlap = 1'b0; prev = 2'b00;
        for (int c = 0; c < 60 && !got_i; c++) begin
            bus.m_ack = 1'b0;
            #1 bus.m_ack = bus.m_req;
            @(negedge clk);
            if (bus.i_ack && bus.d_ack) overlap = 1'b1;
            if (owner == 2'b10 && prev != 2'b10) dgr++;
            if (owner == 2'b01) got_i = 1'b1;
            prev = owner;
            @(posedge clk);
            #1;
        end
        next_grant = 2'b00;
        for (int c = 0; c < 10 && next_grant == 2'b00; c++) begin
            bus.m_ack = 1'b0;
            @(negedge clk);
            next_grant = owner;
            @(posedge clk);
            #1;
        end
        chk("starve_fetch_granted", 76'(got_i), 76'(1));
        chk("starve_data_grants", 76'(dgr), 76'(4));
        chk("starve_ack_overlap", 76'(overlap), 76'(0));
        chk("starve_streak_cleared", 76'(next_grant), 76'(2'b10));

        bus.i_req = 1'b0; bus.d_req = 1'b0; bus.m_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // reset while data owns the bus with m_req high
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = DA1; bus.d_wdata = DB; bus.d_wstrb = 4'hF;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_pre_owner_mreq", 76'({owner, bus.m_req}), 76'({2'b10, 1'b1}));
        rst_n = 1'b0;
        @(posedge clk);
        #1 bus.m_ack = 1'b1;
        @(negedge clk);
        chk("rst_post_state", outs(), 76'(0));
        rst_n = 1'b1;
        bus.m_ack = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_rearbitrate", outs(), {2'b10, 2'b11, DA1, DB, 4'hF, 4'b0000});

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
